// File: rtl/predictor_func_acc_rnd_sat.sv
// Accumulate-round-saturate stage behind the predictor multipliers: sums a framed
// product stream, rescales with round-half-up and clamps to the 64-bit word.
module predictor_func_acc_rnd_sat #(
  parameter int DIN_WIDTH  = 92,
  parameter int ACC_WIDTH  = 100,
  parameter int FRAC_SHIFT = 28,
  parameter int DOUT_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [DIN_WIDTH-1:0]  din,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         out_sat,
  output logic [7:0]                   out_count,
  output logic                         err
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

  state_t                  state, state_nxt;
  logic [ACC_WIDTH-1:0]    acc, acc_nxt, din_ext, launch_val;
  logic [7:0]              cnt, cnt_nxt, cnt_inc, launch_cnt;
  logic                    launch, err_nxt;

  logic                    fin_valid;
  logic [ACC_WIDTH-1:0]    fin;
  logic [7:0]              fin_cnt;

  logic                    r_valid;
  logic signed [ACC_WIDTH:0] r_val;
  logic [7:0]              r_cnt;

  logic signed [ACC_WIDTH:0] rsum, rshift;
  logic [ACC_WIDTH-DOUT_WIDTH+1:0] upper;
  logic                    ovf;
  logic [DOUT_WIDTH-1:0]   sat_val;

  assign din_ext = {{(ACC_WIDTH - DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    launch     = 1'b0;
    launch_val = din_ext;
    launch_cnt = 8'd1;
    err_nxt    = 1'b0;
    if (in_valid) begin
      if (in_first) begin
        // a first beat inside an open sum abandons it and restarts
        err_nxt = (state == ACC);
        if (in_last) begin
          launch    = 1'b1;
          state_nxt = IDLE;
        end else begin
          acc_nxt   = din_ext;
          cnt_nxt   = 8'd1;
          state_nxt = ACC;
        end
      end else if (state == IDLE) begin
        err_nxt = 1'b1;
      end else if (in_last) begin
        launch     = 1'b1;
        launch_val = acc + din_ext;
        launch_cnt = cnt_inc;
        state_nxt  = IDLE;
      end else begin
        acc_nxt = acc + din_ext;
        cnt_nxt = cnt_inc;
      end
    end
  end

  always_comb begin
    rsum    = $signed({fin[ACC_WIDTH-1], fin}) + $signed(HALF);
    rshift  = rsum >>> FRAC_SHIFT;
    upper   = r_val[ACC_WIDTH:DOUT_WIDTH-1];
    ovf     = !((&upper) || !(|upper));
    sat_val = r_val[ACC_WIDTH] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                               : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  end

  // Sum FSM, launch register, rounding stage R and saturation stage S all stall on ce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      fin_valid <= 1'b0;
      fin       <= '0;
      fin_cnt   <= '0;
      r_valid   <= 1'b0;
      r_val     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else if (ce) begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      err       <= err_nxt;
      fin_valid <= launch;
      if (launch) begin
        fin     <= launch_val;
        fin_cnt <= launch_cnt;
      end
      r_valid   <= fin_valid;
      if (fin_valid) begin
        r_val   <= rshift;
        r_cnt   <= fin_cnt;
      end
      out_valid <= r_valid;
      if (r_valid) begin
        dout      <= ovf ? sat_val : r_val[DOUT_WIDTH-1:0];
        out_sat   <= ovf;
        out_count <= r_cnt;
      end
    end
  end

endmodule

// File: tb/tb_predictor_func_acc_rnd_sat.sv
// Directed bench for predictor_func_acc_rnd_sat: hand-computed sums, rounding,
// saturation, ce stalls, framing errors and asynchronous reset.
module tb_predictor_func_acc_rnd_sat;

  logic               clk;
  logic               reset_n;
  logic               ce;
  logic               in_valid;
  logic               in_first;
  logic               in_last;
  logic signed [91:0] din;
  logic               out_valid;
  logic signed [63:0] dout;
  logic               out_sat;
  logic [7:0]         out_count;
  logic               err;

  int passed = 0;
  int total  = 0;

  int          eCycle = 0;
  int          ovCnt = 0;
  int          errCnt = 0;
  int          lastBeat = 0;
  int          lastOvCycle = 0;
  logic [63:0] lastDout = '0;
  logic        lastSat = 1'b0;
  logic [7:0]  lastCount = '0;
  logic [63:0] ovDout[$];
  int          ovCyc[$];

  predictor_func_acc_rnd_sat dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .din       (din),
    .out_valid (out_valid),
    .dout      (dout),
    .out_sat   (out_sat),
    .out_count (out_count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // One clk edge; outputs sampled 1ns later and logged only for enabled edges.
  task automatic tick();
    logic ceNow;
    ceNow = ce;
    @(posedge clk);
    #1;
    if (ceNow) begin
      eCycle++;
      if (out_valid) begin
        ovCnt++;
        lastOvCycle = eCycle;
        lastDout    = dout;
        lastSat     = out_sat;
        lastCount   = out_count;
        ovDout.push_back(dout);
        ovCyc.push_back(eCycle);
      end
      if (err) errCnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic f, input logic l, input logic signed [91:0] d);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    din      = d;
    tick();
    lastBeat = eCycle;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    din      = '0;
  endtask

  task automatic clearLog();
    ovCnt  = 0;
    errCnt = 0;
    ovDout.delete();
    ovCyc.delete();
  endtask

  initial begin
    reset_n  = 1'b0;
    ce       = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    din      = '0;

    idle(2);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_dout",      dout,           64'd0);
    checkOutput("rst_out_sat",   64'(out_sat),   64'd0);
    checkOutput("rst_out_count", 64'(out_count), 64'd0);
    checkOutput("rst_err",       64'(err),       64'd0);
    reset_n = 1'b1;
    idle(2);

    $display("[TB] three-term sum");
    clearLog();
    applyStimulus(1'b1, 1'b0, 92'sd3 <<< 28);
    applyStimulus(1'b0, 1'b0, 92'sd5 <<< 28);
    applyStimulus(1'b0, 1'b1, -(92'sd2 <<< 28));
    idle(4);
    checkOutput("sum3_valid_cnt", 64'(ovCnt), 64'd1);
    checkOutput("sum3_latency",   64'(lastOvCycle - lastBeat), 64'd2);
    checkOutput("sum3_dout",      lastDout, 64'd6);
    checkOutput("sum3_count",     64'(lastCount), 64'd3);
    checkOutput("sum3_sat",       64'(lastSat), 64'd0);
    checkOutput("sum3_err",       64'(errCnt), 64'd0);

    $display("[TB] single-term sums back to back");
    clearLog();
    applyStimulus(1'b1, 1'b1, 92'sd1 <<< 27);
    applyStimulus(1'b1, 1'b1, -(92'sd1 <<< 27));
    applyStimulus(1'b1, 1'b1, -(92'sd1 <<< 27) - 92'sd1);
    idle(4);
    checkOutput("single_valid_cnt", 64'(ovCnt), 64'd3);
    checkOutput("single_half_up",   ovDout[0], 64'd1);
    checkOutput("single_neg_half",  ovDout[1], 64'd0);
    checkOutput("single_below_half", ovDout[2], 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("single_consecutive", 64'(ovCyc[2] - ovCyc[0]), 64'd2);
    checkOutput("single_count",     64'(lastCount), 64'd1);

    $display("[TB] saturation");
    clearLog();
    applyStimulus(1'b1, 1'b0, 92'sd1 <<< 90);
    applyStimulus(1'b0, 1'b1, 92'sd1 <<< 90);
    idle(4);
    checkOutput("sat_pos_dout", lastDout, 64'h7FFF_FFFF_FFFF_FFFF);
    checkOutput("sat_pos_flag", 64'(lastSat), 64'd1);
    applyStimulus(1'b1, 1'b0, -(92'sd1 <<< 90));
    applyStimulus(1'b0, 1'b1, -(92'sd1 <<< 90));
    idle(4);
    checkOutput("sat_min_exact_dout", lastDout, 64'h8000_0000_0000_0000);
    checkOutput("sat_min_exact_flag", 64'(lastSat), 64'd0);
    applyStimulus(1'b1, 1'b0, -(92'sd1 <<< 90));
    applyStimulus(1'b0, 1'b0, -(92'sd1 <<< 90));
    applyStimulus(1'b0, 1'b1, -(92'sd1 <<< 90));
    idle(4);
    checkOutput("sat_neg_dout", lastDout, 64'h8000_0000_0000_0000);
    checkOutput("sat_neg_flag", 64'(lastSat), 64'd1);
    checkOutput("sat_neg_count", 64'(lastCount), 64'd3);

    $display("[TB] ce stall");
    clearLog();
    applyStimulus(1'b1, 1'b0, 92'sd3 <<< 28);
    ce = 1'b0; idle(5); ce = 1'b1;
    applyStimulus(1'b0, 1'b0, 92'sd5 <<< 28);
    ce = 1'b0; idle(5); ce = 1'b1;
    applyStimulus(1'b0, 1'b1, -(92'sd2 <<< 28));
    ce = 1'b0; idle(5); ce = 1'b1;
    idle(2);
    checkOutput("stall_valid_at_k2", 64'(out_valid), 64'd1);
    checkOutput("stall_latency", 64'(lastOvCycle - lastBeat), 64'd2);
    ce = 1'b0; idle(3);
    checkOutput("stall_valid_frozen", 64'(out_valid), 64'd1);
    ce = 1'b1; idle(1);
    checkOutput("stall_valid_drop", 64'(out_valid), 64'd0);
    idle(2);
    checkOutput("stall_valid_cnt", 64'(ovCnt), 64'd1);
    checkOutput("stall_dout",  lastDout, 64'd6);
    checkOutput("stall_count", 64'(lastCount), 64'd3);

    $display("[TB] framing errors");
    clearLog();
    applyStimulus(1'b1, 1'b0, 92'sd7 <<< 28);
    applyStimulus(1'b1, 1'b0, 92'sd1 <<< 28);
    applyStimulus(1'b0, 1'b1, 92'sd2 <<< 28);
    idle(4);
    checkOutput("restart_err_cnt", 64'(errCnt), 64'd1);
    checkOutput("restart_dout",    lastDout, 64'd3);
    checkOutput("restart_count",   64'(lastCount), 64'd2);
    checkOutput("restart_valid",   64'(ovCnt), 64'd1);
    clearLog();
    applyStimulus(1'b0, 1'b1, 92'sd5 <<< 28);
    idle(4);
    checkOutput("orphan_err_cnt", 64'(errCnt), 64'd1);
    checkOutput("orphan_valid",   64'(ovCnt), 64'd0);

    $display("[TB] count saturation over 300 terms");
    clearLog();
    applyStimulus(1'b1, 1'b0, 92'sd1 <<< 28);
    for (int i = 0; i < 298; i++) applyStimulus(1'b0, 1'b0, 92'sd1 <<< 28);
    applyStimulus(1'b0, 1'b1, 92'sd1 <<< 28);
    idle(4);
    checkOutput("long_dout",  lastDout, 64'd300);
    checkOutput("long_count", 64'(lastCount), 64'd255);

    $display("[TB] asynchronous reset mid-sum");
    clearLog();
    applyStimulus(1'b1, 1'b1, 92'sd5 <<< 28);
    applyStimulus(1'b1, 1'b0, 92'sd1 <<< 28);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_dout",      dout,           64'd0);
    checkOutput("arst_out_sat",   64'(out_sat),   64'd0);
    checkOutput("arst_out_count", 64'(out_count), 64'd0);
    checkOutput("arst_err",       64'(err),       64'd0);
    idle(2);
    reset_n = 1'b1;
    clearLog();
    applyStimulus(1'b1, 1'b1, 92'sd1 <<< 28);
    idle(4);
    checkOutput("post_rst_valid", 64'(ovCnt), 64'd1);
    checkOutput("post_rst_dout",  lastDout, 64'd1);
    checkOutput("post_rst_count", 64'(lastCount), 64'd1);
    checkOutput("post_rst_err",   64'(errCnt), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
